// File: rtl/uart_pio_sequencer.sv
// HPS-facing command decoder and byte buffering between the UART PIO exports and a UART core.
// Strobed commands access TX/RX FIFOs, sticky status and control; pio_rdata is registered each cycle.
module uart_pio_sequencer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pio_data,
    input  logic [3:0] pio_flags,
    input  logic [1:0] pio_addr,
    output logic [7:0] pio_rdata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];

    logic          strb_q;
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          rx_ovr_q, rx_ovr_d, cmd_err_q, cmd_err_d;
    logic [1:0]    cmd_seq_q, cmd_seq_d;
    logic [7:0]    rdata_q, rdata_d;

    logic fire, is_wr;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push_req, tx_push, tx_pop, tx_flush;
    logic rx_pop_req, rx_pop, rx_push, rx_flush;
    logic ovr_set, err_set, st_clr;
    logic [AW-1:0] tx_rd_idx;
    logic [7:0] status;

    // Bits [3:2] of the flags PIO are don't-care.
    logic unused_flags;
    assign unused_flags = ^pio_flags[3:2];

    always_comb begin
        fire     = pio_flags[0] & ~strb_q;
        is_wr    = pio_flags[1];
        tx_empty = (tx_cnt_q == '0);
        tx_full  = (tx_cnt_q == FULL_CNT);
        rx_empty = (rx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FULL_CNT);

        tx_pop      = tx_valid_q & tx_ready;
        tx_flush    = fire & is_wr & (pio_addr == 2'd3) & pio_data[0];
        rx_flush    = fire & is_wr & (pio_addr == 2'd3) & pio_data[1];
        tx_push_req = fire & is_wr & (pio_addr == 2'd0);
        tx_push     = tx_push_req & (~tx_full | tx_pop);
        rx_pop_req  = fire & ~is_wr & (pio_addr == 2'd1);
        rx_pop      = rx_pop_req & ~rx_empty;
        rx_push     = rx_valid & (~rx_full | rx_pop) & ~rx_flush;
        ovr_set     = rx_valid & rx_full & ~rx_pop & ~rx_flush;
        err_set     = (tx_push_req & ~tx_push) | (rx_pop_req & rx_empty) |
                      (fire & is_wr & ((pio_addr == 2'd1) | (pio_addr == 2'd2)));
        st_clr      = fire & ~is_wr & (pio_addr == 2'd2);
        status      = {cmd_seq_q, cmd_err_q, rx_ovr_q, rx_full, rx_empty, tx_full, tx_empty};
    end

    always_comb begin
        tx_cnt_d  = tx_cnt_q;
        tx_wptr_d = tx_push ? tx_wptr_q + PTR_ONE : tx_wptr_q;
        tx_rptr_d = tx_pop ? tx_rptr_q + PTR_ONE : tx_rptr_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CNT_ONE;
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
        if (tx_flush) begin
            tx_cnt_d  = '0;
            tx_wptr_d = '0;
            tx_rptr_d = '0;
        end

        // Output stage looks past the current pop but not at a same-cycle push.
        tx_rd_idx  = tx_pop ? tx_rptr_q + PTR_ONE : tx_rptr_q;
        tx_valid_d = ~tx_flush & ((tx_pop ? tx_cnt_q - CNT_ONE : tx_cnt_q) != '0);
        tx_data_d  = tx_mem[tx_rd_idx];

        rx_cnt_d  = rx_cnt_q;
        rx_wptr_d = rx_push ? rx_wptr_q + PTR_ONE : rx_wptr_q;
        rx_rptr_d = rx_pop ? rx_rptr_q + PTR_ONE : rx_rptr_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else if (!rx_push && rx_pop) begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
        if (rx_flush) begin
            rx_cnt_d  = '0;
            rx_wptr_d = '0;
            rx_rptr_d = '0;
        end

        rx_ovr_d  = ovr_set | (rx_ovr_q & ~st_clr);
        cmd_err_d = err_set | (cmd_err_q & ~st_clr);
        cmd_seq_d = fire ? cmd_seq_q + 2'd1 : cmd_seq_q;

        rdata_d = 8'h00;
        unique case (pio_addr)
            2'd0: rdata_d = 8'(tx_cnt_q);
            2'd1: rdata_d = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
            2'd2: rdata_d = status;
            2'd3: rdata_d = 8'(rx_cnt_q);
            default: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr_q] <= pio_data;
        end
        if (rx_push) begin
            rx_mem[rx_wptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strb_q     <= 1'b0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_ovr_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            cmd_seq_q  <= 2'd0;
            rdata_q    <= 8'h00;
        end else begin
            strb_q     <= pio_flags[0];
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_ovr_q   <= rx_ovr_d;
            cmd_err_q  <= cmd_err_d;
            cmd_seq_q  <= cmd_seq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign pio_rdata = rdata_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_pio_sequencer.sv
// Scoreboard bench for uart_pio_sequencer: a queue-based reference model predicts pio_rdata each
// cycle and the TX byte stream; a negedge monitor pops and compares.
module tb_uart_pio_sequencer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pio_data = 8'h00;
    logic [3:0] pio_flags = 4'h0;
    logic [1:0] pio_addr = 2'd0;
    logic [7:0] pio_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    uart_pio_sequencer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .pio_data (pio_data),
        .pio_flags(pio_flags),
        .pio_addr (pio_addr),
        .pio_rdata(pio_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned stamp;
        logic [7:0]  val;
        bit          chk;
        logic [1:0]  addr;
    } rd_exp_t;

    int checks = 0;
    int errors = 0;
    int unsigned edge_cnt = 0;

    // Reference model state
    logic [7:0] tx_exp[$];
    logic [7:0] rx_q[$];
    logic [1:0] m_seq = 2'd0;
    bit m_err = 1'b0;
    bit m_ovr = 1'b0;
    bit m_prev = 1'b0;
    rd_exp_t rd_q[$];
    rd_exp_t mon_e;

    always @(posedge clk) edge_cnt++;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {m_seq, m_err, m_ovr, (rx_q.size() == DEPTH), (rx_q.size() == 0),
                (tx_exp.size() == DEPTH), (tx_exp.size() == 0)};
    endfunction

    task automatic model_reset();
        tx_exp.delete();
        rx_q.delete();
        rd_q.delete();
        m_seq = 2'd0;
        m_err = 1'b0;
        m_ovr = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic model_step();
        bit fire, rx_pop_ok, tx_fl, rx_fl, clr;
        fire = pio_flags[0] && !m_prev;
        m_prev = pio_flags[0];
        rx_pop_ok = 0; tx_fl = 0; rx_fl = 0; clr = 0;
        if (fire) begin
            m_seq = m_seq + 2'd1;
            case (pio_addr)
                2'd0: if (pio_flags[1]) begin
                    if (tx_exp.size() < DEPTH) tx_exp.push_back(pio_data);
                    else m_err = 1'b1;
                end
                2'd1: if (pio_flags[1] || rx_q.size() == 0) m_err = 1'b1;
                      else rx_pop_ok = 1'b1;
                2'd2: if (pio_flags[1]) m_err = 1'b1; else clr = 1'b1;
                default: if (pio_flags[1]) begin
                    tx_fl = pio_data[0];
                    rx_fl = pio_data[1];
                end
            endcase
        end
        if (clr) begin
            m_err = 1'b0;
            m_ovr = 1'b0;
        end
        if (rx_pop_ok) void'(rx_q.pop_front());
        if (rx_fl) rx_q.delete();
        else if (rx_valid) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(rx_data);
            else m_ovr = 1'b1;
        end
        if (tx_fl) tx_exp.delete();
    endtask

    // Called at posedge+1: predict next pio_rdata, advance one clock, apply this cycle's events.
    task automatic cycle();
        rd_exp_t e;
        e.stamp = edge_cnt + 1;
        e.addr  = pio_addr;
        e.chk   = 1'b1;
        case (pio_addr)
            2'd0: e.val = 8'(tx_exp.size());
            2'd1: begin
                if (rx_q.size() > 0) e.val = rx_q[0];
                else begin e.val = 8'h00; e.chk = 1'b0; end
            end
            2'd2: e.val = m_status();
            default: e.val = 8'(rx_q.size());
        endcase
        rd_q.push_back(e);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmd(input bit wr, input logic [1:0] a, input logic [7:0] d);
        pio_addr  = a;
        pio_data  = d;
        pio_flags = {2'b00, wr, 1'b1};
        cycle();
        pio_flags[0] = 1'b0;
        cycle();
    endtask

    task automatic settle(input logic [1:0] a);
        pio_addr = a;
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        pio_flags = 4'h0;
        rx_valid  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check8("tx_valid_async_drop", {7'b0, tx_valid}, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check8("reset_rdata", pio_rdata, 8'h00);
        check8("reset_tx_data", tx_data, 8'h00);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra: got byte 0x%02h, none expected at %0t", tx_data, $time);
                end else begin
                    check8("tx_data", tx_data, tx_exp.pop_front());
                end
            end
            while (rd_q.size() > 0 && rd_q[0].stamp < edge_cnt) void'(rd_q.pop_front());
            if (rd_q.size() > 0 && rd_q[0].stamp == edge_cnt) begin
                mon_e = rd_q.pop_front();
                if (mon_e.chk) check8($sformatf("rdata_addr%0d", mon_e.addr), pio_rdata, mon_e.val);
            end
        end
    end

    initial begin
        logic [1:0] seq0;
        @(posedge clk);
        #1;
        do_reset();
        settle(2'd2);
        check8("status_after_reset", pio_rdata, 8'h05);

        // TX path with backpressure, then burst drain
        tx_ready = 1'b0;
        cmd(1'b1, 2'd0, 8'h41);
        cmd(1'b1, 2'd0, 8'h42);
        cmd(1'b1, 2'd0, 8'h43);
        settle(2'd0);
        check8("tx_occupancy3", pio_rdata, 8'h03);
        settle(2'd2);
        check8("status_seq3", pio_rdata, 8'hC4);
        tx_ready = 1'b1;
        repeat (3) cycle();
        check8("tx_burst_consecutive", 8'(tx_exp.size()), 8'h00);
        check8("tx_valid_idle", {7'b0, tx_valid}, 8'h00);

        // TX full
        tx_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) cmd(1'b1, 2'd0, 8'($urandom));
        settle(2'd2);
        check8("tx_full_err", pio_rdata & 8'h23, 8'h22);
        cmd(1'b0, 2'd2, 8'h00);
        check8("err_cleared", pio_rdata & 8'h20, 8'h00);
        tx_ready = 1'b1;
        repeat (DEPTH + 4) cycle();
        check8("tx_full_drained", 8'(tx_exp.size()), 8'h00);
        check8("tx_valid_after_drain", {7'b0, tx_valid}, 8'h00);

        // RX overrun and ordered pops
        pio_addr = 2'd2;
        for (int i = 0; i <= DEPTH; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h10 + i);
            cycle();
        end
        rx_valid = 1'b0;
        cycle();
        check8("rx_full_overrun", pio_rdata & 8'h18, 8'h18);
        settle(2'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check8("rx_head_order", pio_rdata, 8'(8'h10 + i));
            cmd(1'b0, 2'd1, 8'h00);
        end
        cmd(1'b0, 2'd1, 8'h00);
        settle(2'd2);
        check8("rx_pop_empty_err", pio_rdata & 8'h3C, 8'h34);
        cmd(1'b0, 2'd2, 8'h00);

        // RX flush racing an incoming byte
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            cycle();
        end
        pio_addr  = 2'd3;
        pio_data  = 8'h02;
        pio_flags = 4'b0011;
        rx_data   = 8'($urandom);
        cycle();
        rx_valid  = 1'b0;
        pio_flags = 4'h0;
        cycle();
        cycle();
        check8("rx_flush_race", pio_rdata, 8'h00);

        // Held strobe fires once
        tx_ready  = 1'b0;
        seq0      = m_seq;
        pio_addr  = 2'd0;
        pio_data  = 8'($urandom);
        pio_flags = 4'b0011;
        repeat (10) cycle();
        pio_flags = 4'h0;
        cycle();
        cycle();
        check8("held_strobe_occ", pio_rdata, 8'h01);
        settle(2'd2);
        check8("held_strobe_seq", {6'b0, pio_rdata[7:6]}, {6'b0, seq0 + 2'd1});
        tx_ready = 1'b1;
        repeat (4) cycle();

        // Reset in the middle of traffic
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) cmd(1'b1, 2'd0, 8'($urandom));
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        cycle();
        rx_valid = 1'b0;
        cycle();
        check8("tx_valid_before_reset", {7'b0, tx_valid}, 8'h01);
        do_reset();
        settle(2'd2);
        check8("status_after_midreset", pio_rdata, 8'h05);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic wr;
            wr        = 1'($urandom);
            pio_addr  = 2'($urandom);
            pio_data  = 8'($urandom);
            if (pio_addr == 2'd3 && wr && ($urandom % 8 != 0)) pio_data = 8'h00;
            pio_flags = {2'b00, wr, 1'($urandom)};
            tx_ready  = ($urandom % 100) < ((i < 1500) ? 15 : 80);
            rx_valid  = ($urandom % 3 == 0);
            rx_data   = 8'($urandom);
            cycle();
        end
        pio_flags = 4'h0;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        repeat (2 * DEPTH + 4) cycle();
        check8("random_tx_drained", 8'(tx_exp.size()), 8'h00);
        check8("random_tx_valid_idle", {7'b0, tx_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
